// File: rtl/m6800_pkg.sv
// Shared types and default timing constants for the 6800-style bus cycle sequencer.
package m6800_pkg;

  localparam int unsigned E_PERIOD  = 10;
  localparam int unsigned E_HIGH    = 4;
  localparam int unsigned VMA_PHASE = 2;

  function automatic int unsigned ecnt_width(input int unsigned period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

  localparam int unsigned ECNT_W = ecnt_width(E_PERIOD);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_E,
    VMA,
    DONE,
    HOLD
  } state_t;

endpackage

// File: rtl/m6800_eclk.sv
// Free-running E clock: phase counter ecnt and registered e, aligned so that
// e is high exactly while ecnt >= E_PERIOD-E_HIGH.
module m6800_eclk #(
  parameter int unsigned E_PERIOD = m6800_pkg::E_PERIOD,
  parameter int unsigned E_HIGH   = m6800_pkg::E_HIGH,
  localparam int unsigned CW      = m6800_pkg::ecnt_width(E_PERIOD)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [CW-1:0] ecnt,
  output logic          e
);

  logic [CW-1:0] ecnt_nxt;

  always_comb begin
    ecnt_nxt = ecnt + CW'(1);
    if (ecnt == CW'(E_PERIOD - 1)) begin
      ecnt_nxt = '0;
    end
  end

  // e is derived from the next count so it switches on the same edge as ecnt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ecnt <= '0;
      e    <= 1'b0;
    end else begin
      ecnt <= ecnt_nxt;
      e    <= (ecnt_nxt >= CW'(E_PERIOD - E_HIGH));
    end
  end

endmodule

// File: rtl/m6800_cycle_seq.sv
// CPU-side 6800 peripheral cycle sequencer: answers VPA with a VMA window aligned
// to E and terminates the strobe with cycle_done (plus autovec on IACK cycles).
module m6800_cycle_seq #(
  parameter int unsigned E_PERIOD  = m6800_pkg::E_PERIOD,
  parameter int unsigned E_HIGH    = m6800_pkg::E_HIGH,
  parameter int unsigned VMA_PHASE = m6800_pkg::VMA_PHASE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic as_n,
  input  logic iack,
  input  logic vpa_n,
  output logic e,
  output logic vma_n,
  output logic cycle_done,
  output logic autovec
);

  import m6800_pkg::*;

  localparam int unsigned CW = ecnt_width(E_PERIOD);

  logic [CW-1:0] ecnt;
  logic          vpa_q;
  state_t        state;

  m6800_eclk #(
    .E_PERIOD (E_PERIOD),
    .E_HIGH   (E_HIGH)
  ) u_eclk (
    .clk     (clk),
    .reset_n (reset_n),
    .ecnt    (ecnt),
    .e       (e)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vpa_q      <= 1'b1;
      vma_n      <= 1'b1;
      cycle_done <= 1'b0;
      autovec    <= 1'b0;
    end else begin
      vpa_q      <= vpa_n;
      cycle_done <= 1'b0;
      autovec    <= 1'b0;
      unique case (state)
        IDLE: begin
          vma_n <= 1'b1;
          if (!as_n && !vpa_q) begin
            state <= WAIT_E;
          end
        end
        WAIT_E: begin
          if (as_n) begin
            state <= IDLE;
          end else if (ecnt == CW'(VMA_PHASE)) begin
            state <= VMA;
            vma_n <= 1'b0;
          end
        end
        // abort is tested first so a strobe released at E fall never pulses
        VMA: begin
          if (as_n) begin
            state <= IDLE;
            vma_n <= 1'b1;
          end else if (ecnt == CW'(E_PERIOD - 1)) begin
            state      <= DONE;
            vma_n      <= 1'b1;
            cycle_done <= 1'b1;
            autovec    <= iack;
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (as_n) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          vma_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m6800_cycle_seq.sv
// Self-checking bench for m6800_cycle_seq: directed bus scenarios plus random
// strobes, all compared every cycle against a flag-based behavioural model.
module tb_m6800_cycle_seq;

  localparam int unsigned EP = 10;
  localparam int unsigned EH = 4;
  localparam int unsigned VP = 2;

  logic clk = 1'b0;
  logic reset_n, as_n, iack, vpa_n;
  logic e, vma_n, cycle_done, autovec;

  int checks = 0;
  int errors = 0;

  m6800_cycle_seq #(
    .E_PERIOD  (EP),
    .E_HIGH    (EH),
    .VMA_PHASE (VP)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .as_n       (as_n),
    .iack       (iack),
    .vpa_n      (vpa_n),
    .e          (e),
    .vma_n      (vma_n),
    .cycle_done (cycle_done),
    .autovec    (autovec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase = clocks since reset mod EP; a strobe becomes
  // "waiting" one clock after VPA is seen, opens its window at the VMA phase,
  // closes it at E fall, and is then "used" until as_n goes high.
  int   mph;
  bit   m_vpa_q, waiting, in_vma, used, just_done;
  bit   x_e, x_vma_n, x_done, x_av;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mph = 0; m_vpa_q = 1; waiting = 0; in_vma = 0; used = 0; just_done = 0;
      x_e = 0; x_vma_n = 1; x_done = 0; x_av = 0;
    end else begin
      int  p;
      bit  pulse;
      p = mph;
      pulse = 0;
      if (just_done) just_done = 0;
      else if (as_n) begin waiting = 0; in_vma = 0; used = 0; end
      else if (in_vma) begin
        if (p == EP - 1) begin in_vma = 0; pulse = 1; used = 1; just_done = 1; end
      end else if (waiting) begin
        if (p == VP) begin waiting = 0; in_vma = 1; end
      end else if (!used && !m_vpa_q) waiting = 1;
      m_vpa_q = vpa_n;
      mph = (p + 1) % EP;
      x_e = (mph >= EP - EH);
      x_vma_n = !in_vma;
      x_done = pulse;
      x_av = pulse && iack;
    end
  end

  always @(negedge clk) begin
    chk("cmp_e", e, x_e);
    chk("cmp_vma_n", vma_n, x_vma_n);
    chk("cmp_cycle_done", cycle_done, x_done);
    chk("cmp_autovec", autovec, x_av);
  end

  // Tally of one observation window; indexes count negedges after the drive point
  int vlow, dcnt, acnt, first_ph, first_low_i, done_at, vma0;

  task automatic tally(input int n);
    vlow = 0; dcnt = 0; acnt = 0; first_ph = -1; first_low_i = -1; done_at = -1; vma0 = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) vma0 = vma_n;
      if (!vma_n) begin
        vlow++;
        if (first_ph < 0) begin first_ph = mph; first_low_i = i; end
      end
      if (cycle_done) begin dcnt++; if (done_at < 0) done_at = i; end
      if (autovec) acnt++;
      #1;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 4 * EP; i++) begin
      if (mph == ph) return;
      @(negedge clk);
      #1;
    end
    chk("wait_phase_timeout", mph, ph);
  endtask

  task automatic wait_vma_low();
    for (int i = 0; i < 4 * EP; i++) begin
      if (!vma_n) return;
      @(negedge clk);
      #1;
    end
    chk("wait_vma_timeout", vma_n, 0);
  endtask

  initial begin
    int hi_run, lo_run, last_hi, last_lo, vhigh, k;
    reset_n = 1'b0; as_n = 1'b1; iack = 1'b0; vpa_n = 1'b1;
    step(3);
    chk("rst_e", e, 0);
    chk("rst_vma_n", vma_n, 1);
    chk("rst_cycle_done", cycle_done, 0);
    chk("rst_autovec", autovec, 0);
    reset_n = 1'b1;

    // Idle: E shape and VMA quiet
    hi_run = 0; lo_run = 0; last_hi = 0; last_lo = 0; vhigh = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vma_n) vhigh++;
      if (e) begin
        if (lo_run > 0) last_lo = lo_run;
        lo_run = 0; hi_run++;
      end else begin
        if (hi_run > 0) last_hi = hi_run;
        hi_run = 0; lo_run++;
      end
      #1;
    end
    chk("idle_e_high_len", last_hi, 4);
    chk("idle_e_low_len", last_lo, 6);
    chk("idle_vma_n_high", vhigh, 200);

    // Interrupt acknowledge, VPA sampled at ecnt=0
    as_n = 1'b0; iack = 1'b1;
    wait_phase(0);
    vpa_n = 1'b0;
    tally(12);
    chk("irq_vma_first_phase", first_ph, 3);
    chk("irq_vma_low_len", vlow, 7);
    chk("irq_done_count", dcnt, 1);
    chk("irq_autovec_count", acnt, 1);
    chk("irq_done_at", done_at, 9);
    chk("irq_vma_n_after", vma_n, 1);
    vpa_n = 1'b1; as_n = 1'b1;
    step(3);

    // Late VPA at ecnt=5, non-IACK cycle
    as_n = 1'b0; iack = 1'b0;
    wait_phase(5);
    vpa_n = 1'b0;
    tally(20);
    chk("late_vma_first_i", first_low_i, 7);
    chk("late_vma_first_phase", first_ph, 3);
    chk("late_done_at", done_at, 14);
    chk("late_done_count", dcnt, 1);
    chk("late_autovec_count", acnt, 0);
    vpa_n = 1'b1; as_n = 1'b1;
    step(3);

    // Abort while VMA is low
    as_n = 1'b0; iack = 1'b1;
    wait_phase(0);
    vpa_n = 1'b0;
    wait_vma_low();
    step(2);
    as_n = 1'b1; vpa_n = 1'b1;
    tally(15);
    chk("abort_vma_n_next", vma0, 1);
    chk("abort_done_count", dcnt, 0);
    chk("abort_autovec_count", acnt, 0);

    // Hold: strobe and VPA stay low long after termination
    as_n = 1'b0; vpa_n = 1'b0; iack = 1'b1;
    tally(60);
    chk("hold_done_count", dcnt, 1);
    as_n = 1'b1;
    step(2);
    as_n = 1'b0;
    tally(25);
    chk("hold_retoggle_done_count", dcnt, 1);
    as_n = 1'b1; vpa_n = 1'b1;
    step(3);

    // Reset in the middle of a VMA window
    as_n = 1'b0;
    wait_phase(0);
    vpa_n = 1'b0;
    wait_vma_low();
    reset_n = 1'b0;
    #1;
    chk("rstmid_vma_n", vma_n, 1);
    chk("rstmid_e", e, 0);
    chk("rstmid_cycle_done", cycle_done, 0);
    as_n = 1'b1; vpa_n = 1'b1;
    step(2);
    reset_n = 1'b1;
    k = 0;
    for (int i = 0; i < 2 * EP; i++) begin
      @(negedge clk);
      k++;
      if (e) break;
    end
    #1;
    chk("rstmid_e_first_rise", k, 6);

    // Random strobes, VPA and IACK against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) as_n = ~as_n;
      vpa_n = ($urandom_range(0, 7) < 3) ? 1'b0 : 1'b1;
      iack  = $urandom_range(0, 1) != 0;
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m6800_cycle_seq.md
# m6800_cycle_seq

- CPU-side sequencer for 6800-style peripheral bus cycles: free-running E clock plus VMA handshake.
- Sits opposite the CH375 interrupt glue; responds when that glue pulls VPA low and terminates the bus cycle with an autovector indication.
- Used in the testbed and in the CPU-substitute FPGA build to drive and check the interrupt-acknowledge path end to end.

## Interface
- E_PERIOD, 10, E clock period in clk cycles.
- E_HIGH, 4, number of clk cycles E is high; low for E_PERIOD-E_HIGH.
- VMA_PHASE, 2, E-counter value at which VMA may be asserted; must be < E_PERIOD-E_HIGH.
- clk  in  1  master clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- as_n  in  1  address strobe from bus master; low = bus cycle in progress.
- iack  in  1  current cycle is interrupt acknowledge (FC=111); valid while as_n low.
- vpa_n  in  1  valid peripheral address from glue logic, externally pulled up; z reads as 1.
- e  out  1  E clock.
- vma_n  out  1  valid memory address, active low.
- cycle_done  out  1  one-clk pulse terminating the bus cycle (DTACK substitute).
- autovec  out  1  one-clk pulse, cycle_done & iack; CPU takes autovector.

## Operation
- E counter ecnt counts 0..E_PERIOD-1, then wraps to 0; it is free-running and independent of bus activity.
- e is registered: high when ecnt >= E_PERIOD-E_HIGH.
- vpa_n is registered once into vpa_q; the FSM uses only vpa_q.
- IDLE: vma_n=1. If as_n=0 and vpa_q=0, go to WAIT_E.
- WAIT_E:
  - If as_n=1, go to IDLE (abort).
  - Else if ecnt==VMA_PHASE, go to VMA.
  - A VPA arriving after VMA_PHASE waits for the next E period.
- VMA: vma_n=0.
  - If as_n=1, go to IDLE (abort, no pulse).
  - Else if ecnt==E_PERIOD-1 (E falling edge), go to DONE.
- DONE: vma_n=1, cycle_done=1, autovec=iack, for exactly one clk. Then go to HOLD.
- HOLD: wait for as_n=1, then go to IDLE. This guarantees one termination per strobe even if vpa_n stays low.
- vpa_n returning high after WAIT_E is entered does not cancel the cycle; only as_n cancels.

## Timing
- Reset values: ecnt=0, e=0, vma_n=1, cycle_done=0, autovec=0, vpa_q=1, state=IDLE.
- All outputs are registered; none is combinational from inputs.
- vpa_n low at edge k → vpa_q low after k → WAIT_E after k+1 (if as_n low).
- vma_n falls on the edge where ecnt moves VMA_PHASE→VMA_PHASE+1.
- vma_n rises, and cycle_done pulses, on the edge where ecnt wraps to 0, coincident with e falling.
- With defaults, VMA is low for 7 clk.
- Worst-case VPA-to-done latency: 2 + E_PERIOD + (E_PERIOD-1-VMA_PHASE) clk.
- Simultaneous events:
  - as_n rising on the same edge as the VMA→DONE condition: abort wins, no pulse.
  - vpa_q and ecnt==VMA_PHASE in IDLE: go to WAIT_E only; no skip to VMA.
- Reset mid-cycle: immediate return to reset values. The E phase restarts at 0.

## Structure
- Shared package m6800_pkg holds:
  - state enum {IDLE, WAIT_E, VMA, DONE, HOLD};
  - default constants E_PERIOD, E_HIGH, VMA_PHASE;
  - ecnt width as $clog2(E_PERIOD).
- One sub-module, m6800_eclk: the E counter and registered e. It exports ecnt and e to the FSM.

## Test plan
- Reset released, no bus activity → e period 10 clk, high 4, low 6; vma_n held 1 for 200 clk.
- Interrupt path:
  - stimulus: as_n=0, iack=1; glue drives vpa_n low while ecnt=0;
  - required: vma_n low from ecnt 3 through wrap; cycle_done=autovec=1 for one clk at e fall; vma_n then 1.
- Late VPA:
  - stimulus: vpa_n low at ecnt=5;
  - required: VMA is not asserted until the next period's ecnt=2→3; total latency ≤ 19 clk.
- Abort:
  - stimulus: as_n rises while in VMA;
  - required: vma_n 1 next edge; no cycle_done or autovec pulse; FSM in IDLE.
- Hold:
  - stimulus: vpa_n and as_n held low for 40 clk after DONE;
  - required: exactly one cycle_done pulse; new cycle only after as_n toggles high then low.
- Reset mid-cycle:
  - stimulus: reset_n low during VMA;
  - required: vma_n=1, e=0 asynchronously; after release, e first rises 6 clk later.
